alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational 64-bit ALU (add/sub/and/or/xor/shift units behind an op select) between two requesters.
  - Requester 0: main execute datapath.
  - Requester 1: address/branch-compare unit.
- Fair round-robin arbitration, valid/ready request handshake, programmable multi-cycle execute window, registered result returned to the winning requester.

Parameters:
- WIDTH, 64, operand/result width
- OPW, 4, ALU op-select width (passed through unchanged)
- EXEC_CYCLES, 1, cycles operands are held on the ALU before the result is captured (1..15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_A  in  WIDTH  operand A
- req0_B  in  WIDTH  operand B
- req0_op  in  OPW  ALU operation
- resp0_valid  out  1  result available for requester 0
- resp0_ready  in  1  requester 0 consumes the result
- req1_valid, req1_ready, req1_A, req1_B, req1_op, resp1_valid, resp1_ready: same as requester 0, for requester 1
- resp_data  out  WIDTH  captured result, shared by both requesters
- alu_A  out  WIDTH  operand A to the ALU
- alu_B  out  WIDTH  operand B to the ALU
- alu_op  out  OPW  op select to the ALU
- alu_result  in  WIDTH  ALU combinational result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, immediate):
  - State=IDLE, last_grant=1, so requester 0 wins the first tie.
  - Cycle counter=0. Latched A/B/op=0, so alu_A/alu_B/alu_op=0. resp_data=0.
  - req*_ready=0 except as driven combinationally in IDLE. resp*_valid=0. busy=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Only one valid: that requester is granted.
  - Both valid: grant goes to the requester that is not last_grant.
  - reqN_ready=1 only for the granted requester, only in IDLE. It is combinational from the valids; requesters must not make valid depend on ready.
  - On valid&ready: latch A, B, op and grant id; update last_grant; counter=EXEC_CYCLES-1; go to EXEC.
- EXEC:
  - alu_A/alu_B/alu_op are driven from the latched registers and are stable for the whole window.
  - counter>0: decrement and stay.
  - counter==0: capture alu_result into resp_data; go to RESP.
- RESP:
  - respN_valid=1 for the granted requester only. resp_data is held stable.
  - On respN_ready: go to IDLE. A new request may be accepted on the following cycle, not the same cycle.
  - The ready of the non-granted requester is ignored.
- Latency: accepted at edge T; resp_valid first high in cycle T+EXEC_CYCLES+1. Minimum occupancy is EXEC_CYCLES+2 cycles per operation.
- Arithmetic: the block does no arithmetic. Operands and result pass bit-exact; sign is the ALU's concern.
- Boundary conditions:
  - Requester holds valid through RESP: no second acceptance until IDLE.
  - Requester drops valid before acceptance: nothing latched.
  - Both valid continuously: grants strictly alternate 0,1,0,1…
  - resp_ready held high continuously: RESP lasts exactly 1 cycle.
  - Reset mid-EXEC or mid-RESP: the operation is abandoned, no response is issued, and last_grant returns to 1.
  - Operand changes on req*_A/B after acceptance: no effect on alu_A/alu_B.

Test Plan:
- Single op: req0 with A=123, B=456, op=XOR, EXEC_CYCLES=1 -> req0_ready=1 in the accept cycle; resp0_valid two cycles later with resp_data=435; resp1_valid stays 0.
- Tie: both valid from reset; req0 A=-1111, B=2222 (XOR); req1 A=-3333, B=-4444 (XOR); resp_ready tied high.
  - req0 served first with resp_data=-3321.
  - Then req1 with resp_data=7263.
  - Further ties continue alternating.
- Backpressure: resp0_ready held 0 for 5 cycles -> resp0_valid and resp_data stay stable; req1_ready stays 0; req1 is accepted in the first IDLE cycle after resp0_ready.
- Multi-cycle: EXEC_CYCLES=4; change req0_A after acceptance -> alu_A holds the latched value for 4 cycles; resp0_valid at accept+5; busy=1 throughout.
- Reset mid-EXEC: assert reset during EXEC -> all outputs 0 immediately; no resp*_valid afterward; the next tie grants requester 0.
- Idle: no valids for 10 cycles -> busy=0; alu_A/alu_B/alu_op unchanged; no ready or response.

Source files
------------

// File: rtl/alu_arbiter.sv
// Purpose: round-robin arbiter sharing one combinational ALU between two requesters.
// Latency: accept in cycle T, resp_valid from cycle T+EXEC_CYCLES+1; EXEC_CYCLES+2 cycles per op.
// Backpressure: holds the result in RESP until the winner's resp_ready; no accept outside IDLE.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   reqN_valid/ready      request handshake (ready is combinational from the valids, IDLE only)
//   reqN_A/B/op           operands and op select, latched on acceptance
//   respN_valid/ready     response handshake toward the granted requester
//   resp_data             captured ALU result, shared by both requesters
//   alu_A/B/op            latched operands driven to the external ALU
//   alu_result            combinational ALU result, captured at the end of the window
//   busy                  high whenever an operation is in flight
//
// EXEC_CYCLES must lie in 1..15 (4-bit window counter).
module alu_arbiter #(
  parameter int WIDTH       = 64,
  parameter int OPW         = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [OPW-1:0]   req0_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t           state;
  logic             last_grant;
  logic             grant_id;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] data_q;
  logic             resp0_q;
  logic             resp1_q;
  logic             busy_q;

  logic             idle_ok;
  logic             pick1;
  logic             accept;
  logic             resp_take;

  always_comb begin
    // Ready is suppressed while reset is asserted so every output reads 0 during reset.
    idle_ok    = (state == IDLE) && !reset;
    // Requester 1 wins when it is alone, or on a tie when requester 0 won last time.
    pick1      = req1_valid && (!req0_valid || !last_grant);
    req0_ready = idle_ok && req0_valid && !pick1;
    req1_ready = idle_ok && pick1;
    accept     = req0_ready || req1_ready;
    // Only the granted requester's resp_ready can close the response.
    resp_take  = grant_id ? resp1_ready : resp0_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      cnt        <= 4'd0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      data_q     <= '0;
      resp0_q    <= 1'b0;
      resp1_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant_id   <= pick1;
            last_grant <= pick1;
            a_q        <= pick1 ? req1_A  : req0_A;
            b_q        <= pick1 ? req1_B  : req0_B;
            op_q       <= pick1 ? req1_op : req0_op;
            cnt        <= CNT_INIT;
            busy_q     <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            data_q  <= alu_result;
            resp0_q <= !grant_id;
            resp1_q <= grant_id;
            state   <= RESP;
          end
        end
        RESP: begin
          if (resp_take) begin
            resp0_q <= 1'b0;
            resp1_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operands stay on the ALU from the latch registers, untouched by later request traffic.
  assign alu_A       = a_q;
  assign alu_B       = b_q;
  assign alu_op      = op_q;
  assign resp_data   = data_q;
  assign resp0_valid = resp0_q;
  assign resp1_valid = resp1_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (EXEC_CYCLES=1 and 4) share stimulus,
// each with a behavioural ALU; directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, resp0_ready, resp1_ready;
  logic [63:0] req0_A, req0_B, req1_A, req1_B;
  logic [3:0]  req0_op, req1_op;

  logic        req0_ready, req1_ready, resp0_valid, resp1_valid, busy;
  logic [63:0] resp_data, alu_A, alu_B, alu_result;
  logic [3:0]  alu_op;

  logic        m_req0_ready, m_req1_ready, m_resp0_valid, m_resp1_valid, m_busy;
  logic [63:0] m_resp_data, m_alu_A, m_alu_B, m_alu_result;
  logic [3:0]  m_alu_op;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                        input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[5:0];
      4'd6:    return a >> b[5:0];
      default: return a ^ ~b;
    endcase
  endfunction

  assign alu_result   = alu_f(alu_A, alu_B, alu_op);
  assign m_alu_result = alu_f(m_alu_A, m_alu_B, m_alu_op);

  alu_arbiter #(.WIDTH(64), .OPW(4), .EXEC_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
    .req0_op(req0_op), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
    .req1_op(req1_op), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_result(alu_result), .busy(busy)
  );

  alu_arbiter #(.WIDTH(64), .OPW(4), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(m_req0_ready), .req0_A(req0_A), .req0_B(req0_B),
    .req0_op(req0_op), .resp0_valid(m_resp0_valid), .resp0_ready(resp0_ready),
    .req1_valid(req1_valid), .req1_ready(m_req1_ready), .req1_A(req1_A), .req1_B(req1_B),
    .req1_op(req1_op), .resp1_valid(m_resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(m_resp_data), .alu_A(m_alu_A), .alu_B(m_alu_B), .alu_op(m_alu_op),
    .alu_result(m_alu_result), .busy(m_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    req0_A = 0; req0_B = 0; req1_A = 0; req1_B = 0; req0_op = 0; req1_op = 0;
  endtask

  task automatic apply_reset;
    tick;
    reset = 1;
    clear_inputs();
    tick;
    reset = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    clear_inputs();
    req0_valid = 1; req1_valid = 1;
    #12;
    tests++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags got %b want 00000",
               {req0_ready, req1_ready, resp0_valid, resp1_valid, busy});
    end
    tests++;
    if ({resp_data, alu_A, alu_B, alu_op} !== '0) begin
      fails++;
      $display("FAIL reset_data resp=%h A=%h B=%h op=%h want all 0", resp_data, alu_A, alu_B, alu_op);
    end
    tests++;
    if ({m_req0_ready, m_req1_ready, m_resp0_valid, m_resp1_valid, m_busy, m_alu_A} !== '0) begin
      fails++;
      $display("FAIL reset_dut4 flags=%b A=%h want 0",
               {m_req0_ready, m_req1_ready, m_resp0_valid, m_resp1_valid, m_busy}, m_alu_A);
    end
    req0_valid = 0; req1_valid = 0;
    tick;
    reset = 0;
  endtask

  task automatic test_single;
    apply_reset();
    req0_valid = 1; req0_A = 64'd123; req0_B = 64'd456; req0_op = OP_XOR;
    @(negedge clk);
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++; $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready});
    end
    tick;
    req0_valid = 0; req0_A = '1; req0_B = '1;
    @(negedge clk);
    tests++;
    if ({resp0_valid, resp1_valid, busy, alu_A, alu_B} !== {3'b001, 64'd123, 64'd456}) begin
      fails++;
      $display("FAIL single_exec flags=%b A=%0d B=%0d want 001/123/456",
               {resp0_valid, resp1_valid, busy}, alu_A, alu_B);
    end
    tick;
    resp0_ready = 1;
    @(negedge clk);
    tests++;
    if ({resp0_valid, resp1_valid} !== 2'b10 || resp_data !== 64'd435) begin
      fails++;
      $display("FAIL single_resp valids=%b data=%0d want 10/435", {resp0_valid, resp1_valid}, resp_data);
    end
    tick;
    resp0_ready = 0;
    @(negedge clk);
    tests++;
    if ({resp0_valid, busy} !== 2'b00) begin
      fails++; $display("FAIL single_done got %b want 00", {resp0_valid, busy});
    end
  endtask

  task automatic test_tie;
    logic [63:0] exp_data;
    logic        owner;
    bit          found;
    apply_reset();
    req0_valid = 1; req0_A = -64'sd1111; req0_B = 64'sd2222;  req0_op = OP_XOR;
    req1_valid = 1; req1_A = -64'sd3333; req1_B = -64'sd4444; req1_op = OP_XOR;
    resp0_ready = 1; resp1_ready = 1;
    owner = 0;
    for (int n = 0; n < 6; n++) begin
      found = 0;
      for (int k = 0; k < 8 && !found; k++) begin
        @(negedge clk);
        if (resp0_valid || resp1_valid) found = 1;
        else tick;
      end
      tests++;
      if (!found) begin
        fails++; $display("FAIL tie_timeout op %0d no response within 8 cycles", n);
      end
      exp_data = owner ? 64'sd7263 : -64'sd3321;
      tests++;
      if ({resp0_valid, resp1_valid} !== (owner ? 2'b01 : 2'b10) || resp_data !== exp_data) begin
        fails++;
        $display("FAIL tie_resp op %0d valids=%b data=%h want owner %0d data=%h",
                 n, {resp0_valid, resp1_valid}, resp_data, owner, exp_data);
      end
      tick;
      @(negedge clk);
      tests++;
      if ({resp0_valid, resp1_valid} !== 2'b00) begin
        fails++; $display("FAIL tie_resp_len op %0d valids=%b want 00", n, {resp0_valid, resp1_valid});
      end
      tick;
      owner = ~owner;
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] a0, b0, a1, b1;
    a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
    a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
    apply_reset();
    req0_valid = 1; req0_A = a0; req0_B = b0; req0_op = OP_ADD;
    req1_valid = 1; req1_A = a1; req1_B = b1; req1_op = OP_SUB;
    @(negedge clk);
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++; $display("FAIL bp_grant got %b want 10", {req0_ready, req1_ready});
    end
    tick;
    req0_valid = 0; req0_A = {$urandom, $urandom};
    @(negedge clk);
    tests++;
    if (req1_ready !== 1'b0) begin
      fails++; $display("FAIL bp_exec_ready got %b want 0", req1_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      @(negedge clk);
      tests++;
      if ({resp0_valid, resp1_valid, req1_ready} !== 3'b100 || resp_data !== a0 + b0) begin
        fails++;
        $display("FAIL bp_hold cycle %0d flags=%b data=%h want 100/%h",
                 i, {resp0_valid, resp1_valid, req1_ready}, resp_data, a0 + b0);
      end
    end
    tick;
    resp0_ready = 1;
    @(negedge clk);
    tests++;
    if ({resp0_valid, req1_ready} !== 2'b10) begin
      fails++; $display("FAIL bp_release got %b want 10", {resp0_valid, req1_ready});
    end
    tick;
    resp0_ready = 0;
    @(negedge clk);
    tests++;
    if ({resp0_valid, req1_ready} !== 2'b01) begin
      fails++; $display("FAIL bp_next_accept got %b want 01", {resp0_valid, req1_ready});
    end
    tick;
    req1_valid = 0; resp1_ready = 1;
    tick;
    @(negedge clk);
    tests++;
    if ({resp0_valid, resp1_valid} !== 2'b01 || resp_data !== a1 - b1) begin
      fails++;
      $display("FAIL bp_req1_resp valids=%b data=%h want 01/%h", {resp0_valid, resp1_valid}, resp_data, a1 - b1);
    end
  endtask

  task automatic test_multicycle;
    logic [63:0] a0, b0;
    a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
    apply_reset();
    req0_valid = 1; req0_A = a0; req0_B = b0; req0_op = OP_ADD;
    @(negedge clk);
    tests++;
    if (m_req0_ready !== 1'b1) begin
      fails++; $display("FAIL mc_accept got %b want 1", m_req0_ready);
    end
    tick;
    req0_valid = 0;
    for (int i = 0; i < 4; i++) begin
      req0_A = ~a0 ^ 64'(i); req0_B = {$urandom, $urandom};
      @(negedge clk);
      tests++;
      if (m_alu_A !== a0 || m_alu_B !== b0 || {m_busy, m_resp0_valid} !== 2'b10) begin
        fails++;
        $display("FAIL mc_window cycle %0d A=%h B=%h busy/valid=%b want %h/%h/10",
                 i, m_alu_A, m_alu_B, {m_busy, m_resp0_valid}, a0, b0);
      end
      tick;
    end
    @(negedge clk);
    tests++;
    if ({m_resp0_valid, m_busy} !== 2'b11 || m_resp_data !== a0 + b0) begin
      fails++;
      $display("FAIL mc_resp valid/busy=%b data=%h want 11/%h", {m_resp0_valid, m_busy}, m_resp_data, a0 + b0);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] a0;
    a0 = {$urandom, $urandom};
    apply_reset();
    req0_valid = 1; req0_A = a0; req0_B = ~a0; req0_op = OP_XOR;
    tick;
    req0_valid = 0;
    tick;
    @(negedge clk);
    tests++;
    if ({resp0_valid, resp_data, m_busy, m_resp0_valid} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10}) begin
      fails++;
      $display("FAIL rm_pre resp0=%b data=%h m_busy=%b m_resp0=%b want 1/all-ones/1/0",
               resp0_valid, resp_data, m_busy, m_resp0_valid);
    end
    #2;
    reset = 1;
    #1;
    tests++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy,
         m_req0_ready, m_req1_ready, m_resp0_valid, m_resp1_valid, m_busy} !== 10'b0) begin
      fails++;
      $display("FAIL rm_flags got %b want 0", {req0_ready, req1_ready, resp0_valid, resp1_valid, busy,
               m_req0_ready, m_req1_ready, m_resp0_valid, m_resp1_valid, m_busy});
    end
    tests++;
    if ({resp_data, alu_A, alu_B, m_alu_A, m_alu_B} !== '0) begin
      fails++;
      $display("FAIL rm_data resp=%h A=%h mA=%h want 0", resp_data, alu_A, m_alu_A);
    end
    @(posedge clk);
    #1;
    reset = 0;
    resp0_ready = 1; resp1_ready = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++;
      if ({resp0_valid, resp1_valid, busy, m_resp0_valid, m_resp1_valid, m_busy} !== 6'b0) begin
        fails++;
        $display("FAIL rm_no_resp cycle %0d got %b want 0", i,
                 {resp0_valid, resp1_valid, busy, m_resp0_valid, m_resp1_valid, m_busy});
      end
      tick;
    end
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    tests++;
    if ({req0_ready, req1_ready, m_req0_ready, m_req1_ready} !== 4'b1010) begin
      fails++;
      $display("FAIL rm_tie got %b want 1010", {req0_ready, req1_ready, m_req0_ready, m_req1_ready});
    end
  endtask

  task automatic test_idle;
    logic [63:0] a, b;
    logic [3:0]  op;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 4'($urandom);
    apply_reset();
    req0_valid = 1; req0_A = a; req0_B = b; req0_op = op; resp0_ready = 1;
    tick;
    req0_valid = 0;
    tick;
    tick;
    for (int i = 0; i < 10; i++) begin
      req0_A = {$urandom, $urandom}; req1_A = {$urandom, $urandom};
      req0_op = 4'($urandom); req1_B = {$urandom, $urandom};
      @(negedge clk);
      tests++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy} !== 5'b0 ||
          {alu_A, alu_B, alu_op} !== {a, b, op}) begin
        fails++;
        $display("FAIL idle cycle %0d flags=%b A=%h B=%h op=%h want 0/%h/%h/%h", i,
                 {req0_ready, req1_ready, resp0_valid, resp1_valid, busy}, alu_A, alu_B, alu_op, a, b, op);
      end
      tick;
    end
  endtask

  // Transaction-level reference: one op in flight at a time, fair tie-break
  // against the last winner, response visible EXEC_CYCLES+1 cycles after acceptance.
  task automatic test_random;
    bit          outst;
    bit          owner;
    bit          lw;
    int          cyc, acc_cyc;
    logic [63:0] exp_data;
    bit          e_r0, e_r1, e_rv0, e_rv1;
    apply_reset();
    outst = 0; owner = 0; lw = 1; cyc = 0; acc_cyc = 0; exp_data = 0;
    for (int n = 0; n < 800; n++) begin
      req0_valid  = ($urandom_range(0, 9) < 6);
      req1_valid  = ($urandom_range(0, 9) < 6);
      resp0_ready = $urandom_range(0, 1);
      resp1_ready = $urandom_range(0, 1);
      req0_A = {$urandom, $urandom}; req0_B = {$urandom, $urandom}; req0_op = 4'($urandom);
      req1_A = {$urandom, $urandom}; req1_B = {$urandom, $urandom}; req1_op = 4'($urandom);
      @(negedge clk);
      e_r0  = !outst && req0_valid && (!req1_valid || lw);
      e_r1  = !outst && req1_valid && (!req0_valid || !lw);
      e_rv0 = outst && (cyc - acc_cyc >= 2) && !owner;
      e_rv1 = outst && (cyc - acc_cyc >= 2) && owner;
      tests++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== {e_r0, e_r1, e_rv0, e_rv1}) begin
        fails++;
        $display("FAIL rand_flags cycle %0d got %b want %b", n,
                 {req0_ready, req1_ready, resp0_valid, resp1_valid}, {e_r0, e_r1, e_rv0, e_rv1});
      end
      if (e_rv0 || e_rv1) begin
        tests++;
        if (resp_data !== exp_data) begin
          fails++; $display("FAIL rand_data cycle %0d got %h want %h", n, resp_data, exp_data);
        end
        if (owner ? resp1_ready : resp0_ready) outst = 0;
      end
      if (e_r0) begin
        outst = 1; owner = 0; lw = 0; acc_cyc = cyc;
        exp_data = alu_f(req0_A, req0_B, req0_op);
      end else if (e_r1) begin
        outst = 1; owner = 1; lw = 1; acc_cyc = cyc;
        exp_data = alu_f(req1_A, req1_B, req1_op);
      end
      cyc++;
      tick;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_multicycle();
    test_reset_mid();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
